// File: rtl/bf_core_param.sv
// Parametrised eight-opcode tape machine core with valid/ready byte I/O, end-of-program halt and
// error trap. Define BFCORE_SP_BOUNDS_EN to trap '<' at sp==0 and '>' at sp==TAPE_LEN-1.
module bf_core_param #(
    parameter int unsigned CELL_W   = 8,
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned PC_W     = 16,
    parameter int unsigned PROG_LEN = 65535,
    parameter int unsigned DEPTH_W  = 8,
    parameter int unsigned TAPE_LEN = 65536
) (
    input  logic              clock_i,
    input  logic              reset_i,
    output logic [PC_W-1:0]   pc_o,
    input  logic [2:0]        pmem_data_i,
    output logic [ADDR_W-1:0] sp_o,
    input  logic [CELL_W-1:0] tape_rdata_i,
    output logic              tape_we_o,
    output logic [CELL_W-1:0] tape_wdata_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [CELL_W-1:0] out_data_o,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [CELL_W-1:0] in_data_i,
    output logic              halted_o,
    output logic              error_o
);

    typedef enum logic [3:0] {
        StFetch, StExec, StWb, StSkipF, StSkipB, StOut, StIn, StHalt, StError
    } state_e;

    typedef enum logic [2:0] {
        OpInc, OpDec, OpRight, OpLeft, OpOpen, OpClose, OpOut, OpIn
    } op_e;

    localparam logic [PC_W-1:0]    PcEnd    = PC_W'(PROG_LEN);
    localparam logic [DEPTH_W-1:0] DepthMax = {DEPTH_W{1'b1}};
    localparam logic [DEPTH_W-1:0] DepthOne = DEPTH_W'(1);
`ifdef BFCORE_SP_BOUNDS_EN
    localparam logic [ADDR_W-1:0]  SpLast   = ADDR_W'(TAPE_LEN - 1);
`endif

    if (64'(TAPE_LEN) > (64'd1 << ADDR_W)) begin : g_tape_len_chk
        $error("TAPE_LEN exceeds the sp address range");
    end

    state_e              state_q, state_d;
    op_e                 op_q, op_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [ADDR_W-1:0]   sp_q, sp_d;
    logic [DEPTH_W-1:0]  depth_q, depth_d;
    logic                tape_we_q, tape_we_d;
    logic [CELL_W-1:0]   tape_wdata_q, tape_wdata_d;
    logic                out_valid_q, out_valid_d;
    logic [CELL_W-1:0]   out_data_q, out_data_d;
    logic                in_ready_q, in_ready_d;
    logic                halted_q, halted_d;
    logic                error_q, error_d;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q      <= StFetch;
            op_q         <= OpInc;
            pc_q         <= '0;
            sp_q         <= '0;
            depth_q      <= '0;
            tape_we_q    <= 1'b0;
            tape_wdata_q <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            in_ready_q   <= 1'b0;
            halted_q     <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            pc_q         <= pc_d;
            sp_q         <= sp_d;
            depth_q      <= depth_d;
            tape_we_q    <= tape_we_d;
            tape_wdata_q <= tape_wdata_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            in_ready_q   <= in_ready_d;
            halted_q     <= halted_d;
            error_q      <= error_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        pc_d         = pc_q;
        sp_d         = sp_q;
        depth_d      = depth_q;
        tape_we_d    = 1'b0;
        tape_wdata_d = tape_wdata_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        in_ready_d   = in_ready_q;
        halted_d     = halted_q;
        error_d      = error_q;

        unique case (state_q)
            StFetch: begin
                if (pc_q == PcEnd) begin
                    state_d  = StHalt;
                    halted_d = 1'b1;
                end else begin
                    op_d    = op_e'(pmem_data_i);
                    state_d = StExec;
                end
            end
            StExec: begin
                unique case (op_q)
                    // Cell results are staged so the write strobe is high during WB.
                    OpInc, OpDec: begin
                        tape_we_d    = 1'b1;
                        tape_wdata_d = (op_q == OpInc) ? tape_rdata_i + CELL_W'(1)
                                                       : tape_rdata_i - CELL_W'(1);
                        state_d      = StWb;
                    end
                    OpRight: begin
                        state_d = StWb;
`ifdef BFCORE_SP_BOUNDS_EN
                        if (sp_q == SpLast) begin
                            state_d = StError;
                            error_d = 1'b1;
                        end
`endif
                    end
                    OpLeft: begin
                        state_d = StWb;
`ifdef BFCORE_SP_BOUNDS_EN
                        if (sp_q == '0) begin
                            state_d = StError;
                            error_d = 1'b1;
                        end
`endif
                    end
                    OpOpen: begin
                        pc_d = pc_q + PC_W'(1);
                        if (tape_rdata_i == '0) begin
                            depth_d = DepthOne;
                            state_d = StSkipF;
                        end else begin
                            state_d = StFetch;
                        end
                    end
                    OpClose: begin
                        if (tape_rdata_i == '0) begin
                            pc_d    = pc_q + PC_W'(1);
                            state_d = StFetch;
                        end else if (pc_q == '0) begin
                            state_d = StError;
                            error_d = 1'b1;
                        end else begin
                            depth_d = DepthOne;
                            pc_d    = pc_q - PC_W'(1);
                            state_d = StSkipB;
                        end
                    end
                    OpOut: begin
                        out_valid_d = 1'b1;
                        out_data_d  = tape_rdata_i;
                        state_d     = StOut;
                    end
                    OpIn: begin
                        in_ready_d = 1'b1;
                        state_d    = StIn;
                    end
                endcase
            end
            StWb: begin
                if (op_q == OpRight) begin
                    sp_d = sp_q + ADDR_W'(1);
                end else if (op_q == OpLeft) begin
                    sp_d = sp_q - ADDR_W'(1);
                end
                pc_d    = pc_q + PC_W'(1);
                state_d = StFetch;
            end
            StSkipF: begin
                if (pc_q == PcEnd || (pmem_data_i == OpOpen && depth_q == DepthMax)) begin
                    state_d = StError;
                    error_d = 1'b1;
                end else begin
                    pc_d = pc_q + PC_W'(1);
                    if (pmem_data_i == OpOpen) begin
                        depth_d = depth_q + DepthOne;
                    end else if (pmem_data_i == OpClose) begin
                        depth_d = depth_q - DepthOne;
                        if (depth_q == DepthOne) state_d = StFetch;
                    end
                end
            end
            StSkipB: begin
                if (pmem_data_i == OpClose && depth_q == DepthMax) begin
                    state_d = StError;
                    error_d = 1'b1;
                end else if (pmem_data_i == OpOpen && depth_q == DepthOne) begin
                    // Matching '[' found: resume at the first instruction of the loop body.
                    depth_d = '0;
                    pc_d    = pc_q + PC_W'(1);
                    state_d = StFetch;
                end else if (pc_q == '0) begin
                    state_d = StError;
                    error_d = 1'b1;
                end else begin
                    pc_d = pc_q - PC_W'(1);
                    if (pmem_data_i == OpClose) begin
                        depth_d = depth_q + DepthOne;
                    end else if (pmem_data_i == OpOpen) begin
                        depth_d = depth_q - DepthOne;
                    end
                end
            end
            StOut: begin
                if (out_ready_i) begin
                    out_valid_d = 1'b0;
                    pc_d        = pc_q + PC_W'(1);
                    state_d     = StFetch;
                end
            end
            StIn: begin
                if (in_valid_i) begin
                    in_ready_d   = 1'b0;
                    tape_we_d    = 1'b1;
                    tape_wdata_d = in_data_i;
                    state_d      = StWb;
                end
            end
            StHalt, StError: ;
            default: begin
                state_d = StError;
                error_d = 1'b1;
            end
        endcase
    end

    assign pc_o         = pc_q;
    assign sp_o         = sp_q;
    assign tape_we_o    = tape_we_q;
    assign tape_wdata_o = tape_wdata_q;
    assign out_valid_o  = out_valid_q;
    assign out_data_o   = out_data_q;
    assign in_ready_o   = in_ready_q;
    assign halted_o     = halted_q;
    assign error_o      = error_q;

endmodule

// File: tb/tb_bf_core_param.sv
// Randomised program bench for bf_core_param: a tape-machine interpreter predicts tape writes,
// output bytes and final status; a negedge monitor pops and compares them as the core emits them.
module tb_bf_core_param;

    localparam int unsigned CELL_W   = 8;
    localparam int unsigned ADDR_W   = 8;
    localparam int unsigned PC_W     = 5;
    localparam int unsigned PROG_LEN = 16;
    localparam int unsigned DEPTH_W  = 2;
    localparam int unsigned TAPE_LEN = 256;
    localparam int          MAXD     = 3;
    localparam int          BUDGET   = 200;
    localparam int          CAP      = 20000;
    localparam int          NIN      = 64;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [PC_W-1:0]   pc;
    logic [2:0]        pmem_data;
    logic [ADDR_W-1:0] sp;
    logic [CELL_W-1:0] tape_rdata, tape_wdata, out_data;
    logic [CELL_W-1:0] in_data = '0;
    logic              tape_we, out_valid, in_ready, halted, error;
    logic              out_ready = 1'b0;
    logic              in_valid = 1'b0;

    logic [2:0]        prog [PROG_LEN];
    logic [CELL_W-1:0] tape [TAPE_LEN];
    logic [CELL_W-1:0] inq  [NIN];
    logic              clr_tape = 1'b0;

    typedef struct packed {
        logic              h;
        logic              e;
        logic [ADDR_W-1:0] sp;
        logic [PC_W-1:0]   pc;
    } st_t;

    int  exp_wa[$];
    int  exp_wd[$];
    int  exp_out[$];
    st_t exp_st[$];

    int  checks = 0;
    int  failures = 0;
    bit  mon_en = 1'b0;
    bit  hold_out = 1'b0;
    bit  done_seen = 1'b0;
    int  in_idx = 0;

    bf_core_param #(
        .CELL_W  (CELL_W),
        .ADDR_W  (ADDR_W),
        .PC_W    (PC_W),
        .PROG_LEN(PROG_LEN),
        .DEPTH_W (DEPTH_W),
        .TAPE_LEN(TAPE_LEN)
    ) dut (
        .clock_i     (clk),
        .reset_i     (rst),
        .pc_o        (pc),
        .pmem_data_i (pmem_data),
        .sp_o        (sp),
        .tape_rdata_i(tape_rdata),
        .tape_we_o   (tape_we),
        .tape_wdata_o(tape_wdata),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .halted_o    (halted),
        .error_o     (error)
    );

    initial forever #5 clk = ~clk;

    assign pmem_data  = (int'(pc) < PROG_LEN) ? prog[pc[3:0]] : 3'd0;
    assign tape_rdata = tape[sp];

    always @(posedge clk) begin
        if (clr_tape) begin
            for (int i = 0; i < TAPE_LEN; i++) tape[i] <= '0;
        end else if (tape_we) begin
            tape[sp] <= tape_wdata;
        end
    end

    function automatic void check(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Reference interpreter: plain tape-machine semantics, bracket matching by scanning.
    function automatic bit run_model();
        int  mt [TAPE_LEN];
        int  p = 0, s = 0, k = 0, ip = 0, d = 0;
        bit  err = 1'b0;
        st_t st;
        for (int i = 0; i < TAPE_LEN; i++) mt[i] = 0;
        while (1) begin
            k = k + 1;
            if (k > BUDGET || ip >= NIN) return 1'b0;
            if (p == PROG_LEN) break;
            case (prog[p])
                3'd0, 3'd1: begin
                    mt[s] = (mt[s] + ((prog[p] == 3'd0) ? 1 : 255)) % 256;
                    exp_wa.push_back(s);
                    exp_wd.push_back(mt[s]);
                    p++;
                end
                3'd2: begin
`ifdef BFCORE_SP_BOUNDS_EN
                    if (s == TAPE_LEN - 1) begin err = 1'b1; break; end
`endif
                    s = (s + 1) % 256;
                    p++;
                end
                3'd3: begin
`ifdef BFCORE_SP_BOUNDS_EN
                    if (s == 0) begin err = 1'b1; break; end
`endif
                    s = (s + 255) % 256;
                    p++;
                end
                3'd4: begin
                    if (mt[s] != 0) begin
                        p++;
                    end else begin
                        d = 1;
                        p++;
                        forever begin
                            if (p == PROG_LEN) begin err = 1'b1; break; end
                            if (prog[p] == 3'd4) begin
                                if (d == MAXD) begin err = 1'b1; break; end
                                d++;
                            end else if (prog[p] == 3'd5) begin
                                d--;
                                if (d == 0) break;
                            end
                            p++;
                        end
                        if (err) break;
                        p++;
                    end
                end
                3'd5: begin
                    if (mt[s] == 0) begin
                        p++;
                    end else begin
                        if (p == 0) begin err = 1'b1; break; end
                        d = 1;
                        p--;
                        forever begin
                            if (prog[p] == 3'd5) begin
                                if (d == MAXD) begin err = 1'b1; break; end
                                d++;
                            end else if (prog[p] == 3'd4) begin
                                d--;
                                if (d == 0) break;
                            end
                            if (p == 0) begin err = 1'b1; break; end
                            p--;
                        end
                        if (err) break;
                        p++;
                    end
                end
                3'd6: begin
                    exp_out.push_back(mt[s]);
                    p++;
                end
                default: begin
                    mt[s] = int'(inq[ip]);
                    ip++;
                    exp_wa.push_back(s);
                    exp_wd.push_back(mt[s]);
                    p++;
                end
            endcase
        end
        st.h  = !err;
        st.e  = err;
        st.sp = ADDR_W'(s);
        st.pc = PC_W'(p);
        exp_st.push_back(st);
        return 1'b1;
    endfunction

    function automatic void flush_exp();
        exp_wa.delete();
        exp_wd.delete();
        exp_out.delete();
        exp_st.delete();
    endfunction

    function automatic logic [2:0] op_of_char(byte c);
        case (c)
            "+": return 3'd0;
            "-": return 3'd1;
            ">": return 3'd2;
            "<": return 3'd3;
            "[": return 3'd4;
            "]": return 3'd5;
            ".": return 3'd6;
            default: return 3'd7;
        endcase
    endfunction

    function automatic void load_str(string s, byte pad);
        for (int i = 0; i < PROG_LEN; i++) begin
            prog[i] = (i < s.len()) ? op_of_char(s[i]) : op_of_char(pad);
        end
    endfunction

    function automatic void gen_random();
        int r;
        for (int i = 0; i < PROG_LEN; i++) begin
            r = int'($urandom_range(0, 15));
            prog[i] = (r < 4) ? 3'd0 : (r < 6) ? 3'd1 : (r < 8) ? 3'd2 : (r < 10) ? 3'd3 :
                      (r < 12) ? 3'd4 : (r < 14) ? 3'd5 : (r < 15) ? 3'd6 : 3'd7;
        end
        for (int i = 0; i < NIN; i++) inq[i] = CELL_W'($urandom_range(0, 3) == 0 ? 0 : $urandom);
    endfunction

    // Driver and monitor share one negedge process so handshake decisions are race-free.
    initial begin
        bit          in_hs = 1'b0;
        bit          ov_prev = 1'b0, ohs_prev = 1'b0, ir_prev = 1'b0, ihs_prev = 1'b0;
        logic [7:0]  od_prev = '0;
        int          a, dv;
        st_t         st;
        forever begin
            @(negedge clk);
            if (rst) begin
                in_idx = 0;
                in_hs = 1'b0;
                done_seen = 1'b0;
                ov_prev = 1'b0;
                ir_prev = 1'b0;
            end else if (in_hs) begin
                in_idx++;
            end
            out_ready = hold_out ? 1'b0 : ($urandom_range(0, 2) != 0);
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = inq[in_idx % NIN];
            in_hs     = in_valid && in_ready && !rst;
            if (mon_en && !rst) begin
                if (ov_prev && !ohs_prev) begin
                    check("out_valid_held", out_valid, 1);
                    check("out_data_held", out_data, od_prev);
                end
                if (ir_prev && !ihs_prev) check("in_ready_held", in_ready, 1);
                if (tape_we) begin
                    if (exp_wa.size() == 0) begin
                        check("unexpected_tape_write", 1, 0);
                    end else begin
                        a  = exp_wa.pop_front();
                        dv = exp_wd.pop_front();
                        check("tape_write_addr", sp, a);
                        check("tape_write_data", tape_wdata, dv);
                    end
                end
                if (out_valid && out_ready) begin
                    if (exp_out.size() == 0) check("unexpected_out_byte", 1, 0);
                    else check("out_byte", out_data, exp_out.pop_front());
                end
                if ((halted || error) && !done_seen) begin
                    done_seen = 1'b1;
                    if (exp_st.size() == 0) begin
                        check("unexpected_stop", 1, 0);
                    end else begin
                        st = exp_st.pop_front();
                        check("halted", halted, st.h);
                        check("error", error, st.e);
                        check("final_sp", sp, st.sp);
                        if (st.h) check("final_pc", pc, st.pc);
                    end
                end
                ov_prev  = out_valid;
                od_prev  = out_data;
                ohs_prev = out_valid && out_ready;
                ir_prev  = in_ready;
                ihs_prev = in_valid && in_ready;
            end
        end
    end

    // Called with rst high: clears the tape, loads expectations, releases reset.
    task automatic start_prog();
        flush_exp();
        clr_tape = 1'b1;
        @(posedge clk);
        #1 clr_tape = 1'b0;
        void'(run_model());
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic finish_prog();
        int cyc = 0;
        while (!done_seen && cyc < CAP) begin
            @(negedge clk);
            cyc++;
        end
        check("program_completes", done_seen, 1);
        repeat (4) @(negedge clk);
        check("writes_left", exp_wa.size(), 0);
        check("outputs_left", exp_out.size(), 0);
        check("status_left", exp_st.size(), 0);
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    initial begin
        int cyc;
        for (int i = 0; i < NIN; i++) inq[i] = CELL_W'($urandom);
        load_str("+++.", "-");
        repeat (3) @(posedge clk);
        #1;
        check("reset_pc", pc, 0);
        check("reset_sp", sp, 0);
        check("reset_tape_we", tape_we, 0);
        check("reset_out_valid", out_valid, 0);
        check("reset_in_ready", in_ready, 0);
        check("reset_halted", halted, 0);
        check("reset_error", error, 0);
        mon_en = 1'b1;

        // Hold the consumer off, then reset in the middle of the output wait.
        hold_out = 1'b1;
        start_prog();
        cyc = 0;
        while (!out_valid && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        repeat (5) @(negedge clk);
        check("held_out_valid", out_valid, 1);
        check("held_out_data", out_data, 3);
        check("tape0_after_three_incs", tape[0], 3);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_out_valid", out_valid, 0);
        check("rst_in_out_pc", pc, 0);
        check("rst_in_out_sp", sp, 0);
        check("rst_in_out_halted", halted, 0);
        hold_out = 1'b0;
        start_prog();
        finish_prog();

        load_str("[+[-]].", ".");
        start_prog();
        finish_prog();
        load_str("<.,.", ".");
        start_prog();
        finish_prog();
        load_str("]", "+");
        start_prog();
        finish_prog();

        for (int n = 0; n < 30; n++) begin
            do begin
                gen_random();
                flush_exp();
            end while (!run_model());
            start_prog();
            finish_prog();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
